fb_bank_scheduler: RTL and testbench
====================================

// Module: fb_bank_scheduler
// PURPOSE
// Double-buffered framebuffer controller between the video timing chain and one
// single-port BRAM pair holding two frame banks. The display read path has strict
// per-cycle priority. A pixel writer (camera or draw engine) fills the back bank
// through a valid/ready handshake. Banks swap only on the timing generator's
// new-frame pulse, after the writer has declared its frame complete.
// PARAMETERS
// ADDR_W       16  pixel address width within one bank
// DATA_W       16  pixel word width
// MEM_LATENCY  2   BRAM read latency, cycles from mem_addr_out to mem_dout_in
// PORTS
// pixel_clk_in      in   1         pixel clock; the only clock
// rst_in            in   1         reset, synchronous, active-low
// nf_in             in   1         single-cycle new-frame pulse from timing generator
// rd_req_in         in   1         display fetch request; always accepted
// rd_addr_in        in   ADDR_W    display fetch address
// rd_data_out       out  DATA_W    fetched pixel
// rd_valid_out      out  1         rd_data_out valid
// wr_valid_in       in   1         writer has a pixel
// wr_addr_in        in   ADDR_W    writer address
// wr_data_in        in   DATA_W    writer pixel
// wr_ready_out      out  1         write accepted when wr_valid_in && wr_ready_out
// wr_frame_done_in  in   1         single-cycle pulse: back bank is complete
// mem_addr_out      out  ADDR_W+1  {bank, addr} to BRAM
// mem_we_out        out  1         BRAM write enable
// mem_din_out       out  DATA_W    BRAM write data
// mem_dout_in       in   DATA_W    BRAM read data
// disp_bank_out     out  1         bank currently displayed
// swap_pending_out  out  1         high in S_WAIT_SWAP
// repeat_cnt_out    out  8         frames re-shown because no new frame was ready; saturates at 255
// BEHAVIOUR
// - Reset (rst_in==0 at an edge): state S_FILL, disp_bank_out=0, repeat_cnt_out=0,
//   mem_we_out=0, mem_addr_out=0, mem_din_out=0, rd_valid_out=0, rd_data_out=0,
//   and the read valid pipeline is flushed. In-flight reads are dropped; no rd_valid_out after reset.
// - wr_ready_out = rst_in && state==S_FILL && !rd_req_in (combinational).
// - Port arbitration per cycle: a read takes the port if rd_req_in=1. Otherwise an accepted
//   write takes it. Otherwise the port is idle with mem_we_out=0.
// - Memory outputs are registered. A request at cycle t drives mem_* at t+1:
//   read -> mem_addr_out={disp_bank_out, rd_addr_in}, mem_we_out=0;
//   write -> mem_addr_out={~disp_bank_out, wr_addr_in}, mem_we_out=1, mem_din_out=wr_data_in.
//   On an idle cycle mem_addr_out holds its value and mem_we_out=0.
// - Read latency: rd_valid_out=1 at t+2+MEM_LATENCY (4 by default), with
//   rd_data_out = mem_dout_in registered at the same edge. A 1-bit valid shift
//   register of depth 1+MEM_LATENCY tracks reads. Back-to-back reads give one result per cycle.
// - Bank selection uses the disp_bank_out value before the clock edge. A request in
//   the swap cycle uses the old bank.
// - FSM:
//   S_FILL: wr_frame_done_in -> S_WAIT_SWAP. nf_in with no frame done -> repeat_cnt++ (saturating).
//   S_WAIT_SWAP: writes blocked. nf_in -> disp_bank_out toggles, go to S_FILL.
//     wr_frame_done_in is ignored in this state.
//   nf_in and wr_frame_done_in together in S_FILL -> repeat_cnt++ and go to S_WAIT_SWAP.
//     The swap happens on the next nf_in.
// - A write accepted in the same cycle as wr_frame_done_in is still performed.
// - repeat_cnt_out holds at 255 once reached.
// TESTING
// 1 Reset: hold rst_in=0 for 3 cycles with rd_req_in=1 -> all outputs 0, wr_ready_out=0, no rd_valid_out.
// 2 Read latency: preload bank0 addr 5 = 0xBEEF; rd_req_in=1 addr 5 at cycle t ->
//   mem_addr_out=0x00005 at t+1, rd_valid_out=1 and rd_data_out=0xBEEF at t+4.
// 3 Priority: wr_valid_in held with reads on cycles 0-3, no read on cycle 4 ->
//   wr_ready_out=0 for cycles 0-3, write accepted at cycle 4,
//   mem_addr_out={1,addr} with mem_we_out=1 at cycle 5.
// 4 Swap: wr_frame_done_in pulse, then nf_in 10 cycles later ->
//   swap_pending_out=1 for those 10 cycles, wr_ready_out=0,
//   disp_bank_out goes 0->1 after nf_in, state returns to S_FILL.
// 5 Repeat: 300 nf_in pulses with no frame done -> repeat_cnt_out=255, disp_bank_out stays 0.
//   nf_in with frame done in the same cycle -> count+1, swap on the following nf_in.
// 6 Mid-op reset: issue 3 reads, then assert reset at t+2 ->
//   no rd_valid_out afterwards, disp_bank_out=0.

Source files
------------

// File: rtl/fb_bank_scheduler.sv
// fb_bank_scheduler: double-buffered framebuffer bank arbiter with read-priority BRAM port
module fb_bank_scheduler #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic              nf_in,
  input  logic              rd_req_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  output logic [DATA_W-1:0] rd_data_out,
  output logic              rd_valid_out,
  input  logic              wr_valid_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [DATA_W-1:0] wr_data_in,
  output logic              wr_ready_out,
  input  logic              wr_frame_done_in,
  output logic [ADDR_W:0]   mem_addr_out,
  output logic              mem_we_out,
  output logic [DATA_W-1:0] mem_din_out,
  input  logic [DATA_W-1:0] mem_dout_in,
  output logic              disp_bank_out,
  output logic              swap_pending_out,
  output logic [7:0]        repeat_cnt_out
);
  typedef enum logic {S_FILL, S_WAIT_SWAP} state_t;
  state_t             state, state_d;
  logic               disp_d;
  logic [7:0]         rpt_d;
  logic [MEM_LATENCY:0] vsr;
  logic               fill, wr_acc;
  assign fill             = state == S_FILL;
  assign wr_ready_out     = rst_in && fill && !rd_req_in;
  assign wr_acc           = wr_valid_in && wr_ready_out;
  assign swap_pending_out = state == S_WAIT_SWAP;
  always_comb begin
    state_d = fill ? (wr_frame_done_in ? S_WAIT_SWAP : S_FILL) : (nf_in ? S_FILL : S_WAIT_SWAP);
    disp_d  = disp_bank_out ^ (!fill && nf_in);
    rpt_d   = (fill && nf_in && repeat_cnt_out != 8'hFF) ? repeat_cnt_out + 8'd1 : repeat_cnt_out;
  end
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      state          <= S_FILL;
      disp_bank_out  <= 1'b0;
      repeat_cnt_out <= 8'd0;
      mem_we_out     <= 1'b0;
      mem_addr_out   <= '0;
      mem_din_out    <= '0;
      rd_valid_out   <= 1'b0;
      rd_data_out    <= '0;
      vsr            <= '0;
    end else begin
      state          <= state_d;
      disp_bank_out  <= disp_d;
      repeat_cnt_out <= rpt_d;
      mem_we_out     <= wr_acc;
      if (rd_req_in)
        mem_addr_out <= {disp_bank_out, rd_addr_in};
      else if (wr_acc) begin
        mem_addr_out <= {~disp_bank_out, wr_addr_in};
        mem_din_out  <= wr_data_in;
      end
      vsr            <= (vsr << 1) | (MEM_LATENCY+1)'(rd_req_in);
      rd_valid_out   <= vsr[MEM_LATENCY];
      if (vsr[MEM_LATENCY])
        rd_data_out  <= mem_dout_in;
    end
  end
endmodule

// File: tb/tb_fb_bank_scheduler.sv
// tb_fb_bank_scheduler: directed self-checking bench with a 2-cycle BRAM model
module tb_fb_bank_scheduler;
  logic        pixel_clk_in = 1'b0;
  logic        rst_in, nf_in, rd_req_in, wr_valid_in, wr_frame_done_in;
  logic [15:0] rd_addr_in, wr_addr_in, wr_data_in, mem_dout_in, rd_data_out, mem_din_out;
  logic        rd_valid_out, wr_ready_out, mem_we_out, disp_bank_out, swap_pending_out;
  logic [16:0] mem_addr_out;
  logic [7:0]  repeat_cnt_out;
  logic [15:0] mem [0:131071];
  logic [15:0] d1;
  int n_asrt = 0, n_fail = 0;
  always #5 pixel_clk_in = ~pixel_clk_in;
  fb_bank_scheduler dut (
    .pixel_clk_in(pixel_clk_in), .rst_in(rst_in), .nf_in(nf_in),
    .rd_req_in(rd_req_in), .rd_addr_in(rd_addr_in), .rd_data_out(rd_data_out),
    .rd_valid_out(rd_valid_out), .wr_valid_in(wr_valid_in), .wr_addr_in(wr_addr_in),
    .wr_data_in(wr_data_in), .wr_ready_out(wr_ready_out), .wr_frame_done_in(wr_frame_done_in),
    .mem_addr_out(mem_addr_out), .mem_we_out(mem_we_out), .mem_din_out(mem_din_out),
    .mem_dout_in(mem_dout_in), .disp_bank_out(disp_bank_out),
    .swap_pending_out(swap_pending_out), .repeat_cnt_out(repeat_cnt_out)
  );
  always @(posedge pixel_clk_in) begin
    if (!rst_in) mem[5] <= 16'hBEEF;
    if (mem_we_out) mem[mem_addr_out] <= mem_din_out;
    d1          <= mem[mem_addr_out];
    mem_dout_in <= d1;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge pixel_clk_in);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst_in = 1'b0; nf_in = 1'b0; rd_req_in = 1'b1; rd_addr_in = 16'd5;
    wr_valid_in = 1'b0; wr_addr_in = '0; wr_data_in = '0; wr_frame_done_in = 1'b0;
    step(3);
    check("rst_addr", 32'(mem_addr_out), 0);
    check("rst_we", 32'(mem_we_out), 0);
    check("rst_din", 32'(mem_din_out), 0);
    check("rst_rvalid", 32'(rd_valid_out), 0);
    check("rst_rdata", 32'(rd_data_out), 0);
    check("rst_disp", 32'(disp_bank_out), 0);
    check("rst_rpt", 32'(repeat_cnt_out), 0);
    check("rst_pend", 32'(swap_pending_out), 0);
    check("rst_ready_rd", 32'(wr_ready_out), 0);
    rd_req_in = 1'b0; #1;
    check("rst_ready_idle", 32'(wr_ready_out), 0);
    rst_in = 1'b1; #1;
    check("ready_after_rst", 32'(wr_ready_out), 1);
    step();
    rd_req_in = 1'b1; rd_addr_in = 16'd5;
    step();
    rd_req_in = 1'b0;
    check("rd_addr_t1", 32'(mem_addr_out), 32'h00005);
    check("rd_we_t1", 32'(mem_we_out), 0);
    step(2);
    check("rd_valid_t3", 32'(rd_valid_out), 0);
    step();
    check("rd_valid_t4", 32'(rd_valid_out), 1);
    check("rd_data_t4", 32'(rd_data_out), 32'hBEEF);
    step();
    check("rd_valid_t5", 32'(rd_valid_out), 0);
    wr_valid_in = 1'b1; wr_addr_in = 16'h0123; wr_data_in = 16'hCAFE;
    for (int i = 0; i < 4; i++) begin
      rd_req_in = 1'b1; rd_addr_in = 16'(i); #1;
      check("prio_ready_blocked", 32'(wr_ready_out), 0);
      step();
      check("prio_we_blocked", 32'(mem_we_out), 0);
      check("prio_rd_addr", 32'(mem_addr_out), 32'(i));
    end
    rd_req_in = 1'b0; #1;
    check("prio_ready_free", 32'(wr_ready_out), 1);
    step();
    wr_valid_in = 1'b0;
    check("wr_addr", 32'(mem_addr_out), 32'h10123);
    check("wr_we", 32'(mem_we_out), 1);
    check("wr_din", 32'(mem_din_out), 32'hCAFE);
    step();
    check("idle_we", 32'(mem_we_out), 0);
    check("idle_addr_hold", 32'(mem_addr_out), 32'h10123);
    step(4);
    wr_frame_done_in = 1'b1;
    step();
    wr_frame_done_in = 1'b0; wr_valid_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("swap_pend", 32'(swap_pending_out), 1);
      check("swap_ready", 32'(wr_ready_out), 0);
      wr_frame_done_in = (i == 4);
      step();
      wr_frame_done_in = 1'b0;
      check("swap_we_blocked", 32'(mem_we_out), 0);
    end
    check("swap_disp_before", 32'(disp_bank_out), 0);
    nf_in = 1'b1; wr_valid_in = 1'b0;
    step();
    nf_in = 1'b0;
    check("swap_disp_after", 32'(disp_bank_out), 1);
    check("swap_pend_after", 32'(swap_pending_out), 0);
    check("swap_rpt", 32'(repeat_cnt_out), 0);
    check("swap_ready_after", 32'(wr_ready_out), 1);
    rd_req_in = 1'b1; rd_addr_in = 16'h0123;
    step();
    rd_req_in = 1'b0;
    check("bank1_rd_addr", 32'(mem_addr_out), 32'h10123);
    step(3);
    check("bank1_rd_valid", 32'(rd_valid_out), 1);
    check("bank1_rd_data", 32'(rd_data_out), 32'hCAFE);
    step(2);
    rd_req_in = 1'b1; rd_addr_in = 16'd7;
    step(2);
    rst_in = 1'b0;
    step();
    rd_req_in = 1'b0;
    step();
    rst_in = 1'b1;
    check("midrst_disp", 32'(disp_bank_out), 0);
    check("midrst_valid", 32'(rd_valid_out), 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("midrst_no_valid", 32'(rd_valid_out), 0);
    end
    for (int i = 0; i < 300; i++) begin
      nf_in = 1'b1;
      step();
      nf_in = 1'b0;
      step();
      if (i == 253) check("rpt_254", 32'(repeat_cnt_out), 254);
      if (i == 254) check("rpt_255", 32'(repeat_cnt_out), 255);
    end
    check("rpt_sat", 32'(repeat_cnt_out), 255);
    check("rpt_disp", 32'(disp_bank_out), 0);
    check("rpt_pend", 32'(swap_pending_out), 0);
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
    check("rpt_cleared", 32'(repeat_cnt_out), 0);
    nf_in = 1'b1; wr_frame_done_in = 1'b1; wr_valid_in = 1'b1;
    wr_addr_in = 16'h0042; wr_data_in = 16'h1234; #1;
    check("combo_ready", 32'(wr_ready_out), 1);
    step();
    nf_in = 1'b0; wr_frame_done_in = 1'b0; wr_valid_in = 1'b0;
    check("combo_rpt", 32'(repeat_cnt_out), 1);
    check("combo_pend", 32'(swap_pending_out), 1);
    check("combo_disp", 32'(disp_bank_out), 0);
    check("combo_we", 32'(mem_we_out), 1);
    check("combo_addr", 32'(mem_addr_out), 32'h10042);
    check("combo_din", 32'(mem_din_out), 32'h1234);
    step(3);
    check("combo_disp_hold", 32'(disp_bank_out), 0);
    nf_in = 1'b1;
    step();
    nf_in = 1'b0;
    check("combo_swap_disp", 32'(disp_bank_out), 1);
    check("combo_swap_pend", 32'(swap_pending_out), 0);
    check("combo_swap_rpt", 32'(repeat_cnt_out), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
